// File: rtl/axi_lat_responder.sv
// AXI slave that answers single-beat reads and writes after a programmable,
// cycle-exact latency measured against a free-running 32-bit timestamp.

module axi_lat_fifo #(
    parameter int PW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [PW-1:0]              push_data,
    input  logic                       pop,
    output logic [PW-1:0]              head_data,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_data = mem[rptr];
    assign full      = (count == CW'(DEPTH));
endmodule

module axi_lat_resp_q #(
    parameter int PW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [31:0]                now,
    input  logic                       push,
    input  logic [PW-1:0]              push_data,
    input  logic [31:0]                push_due,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PW-1:0]              out_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {Q_IDLE, Q_WAIT, Q_SEND} q_state_t;
    q_state_t state;

    logic [PW-1:0] mem_data [DEPTH];
    logic [31:0]   mem_due  [DEPTH];
    logic [AW-1:0] wptr, rptr, head_idx;
    logic [CW-1:0] remain;
    logic [PW-1:0] nxt_data;
    logic [31:0]   nxt_due, slack;
    logic          pop, nxt_present, nxt_due_ok;

    assign pop       = (state == Q_SEND) && out_ready;
    assign out_valid = (state == Q_SEND);
    assign full      = (count == CW'(DEPTH));

    // Look one cycle ahead (queue after this edge, now+1) so the registered
    // valid rises exactly in the cycle the head entry becomes due.
    always_comb begin
        remain   = count - CW'(pop);
        head_idx = pop ? rptr + AW'(1) : rptr;
        nxt_data = mem_data[head_idx];
        nxt_due  = mem_due[head_idx];
        if (remain == '0) begin
            nxt_data = push_data;
            nxt_due  = push_due;
        end
        nxt_present = (remain != '0) || push;
        slack       = now + 32'd1 - nxt_due;
        nxt_due_ok  = !slack[31];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr] <= push_data;
            mem_due[wptr]  <= push_due;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= Q_IDLE;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            out_data <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (!nxt_present) begin
                state <= Q_IDLE;
            end else begin
                out_data <= nxt_data;
                state    <= nxt_due_ok ? Q_SEND : Q_WAIT;
            end
        end
    end
endmodule

module axi_lat_responder #(
    parameter int ID_W   = 12,
    parameter int DATA_W = 512,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       cfg_rd_latency,
    input  logic [15:0]       cfg_wr_latency,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [63:0]       s_axi_araddr,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    input  logic              s_axi_wlast,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic [7:0]        rd_outstanding,
    output logic [7:0]        wr_outstanding
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0] now;
    logic        ready_en;

    // ready_en keeps every ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            now      <= '0;
            ready_en <= 1'b0;
        end else begin
            now      <= now + 32'd1;
            ready_en <= 1'b1;
        end
    end

    logic             rd_full, ar_hs;
    logic [CW-1:0]    rd_cnt;
    logic [31:0]      rd_lat;
    logic [ID_W+63:0] r_head;

    assign s_axi_arready = ready_en && !rd_full;
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign rd_lat        = (cfg_rd_latency == 16'd0) ? 32'd1 : {16'd0, cfg_rd_latency};

    axi_lat_resp_q #(.PW(ID_W + 64), .DEPTH(DEPTH)) u_rd_q (
        .clk       (clk),
        .reset_n   (reset_n),
        .now       (now),
        .push      (ar_hs),
        .push_data ({s_axi_arid, s_axi_araddr}),
        .push_due  (now + rd_lat),
        .full      (rd_full),
        .count     (rd_cnt),
        .out_valid (s_axi_rvalid),
        .out_ready (s_axi_rready),
        .out_data  (r_head)
    );

    assign s_axi_rid   = r_head[ID_W+63:64];
    assign s_axi_rdata = {(DATA_W/64){r_head[63:0]}};
    assign s_axi_rresp = 2'b00;
    assign s_axi_rlast = s_axi_rvalid;

    logic             aw_full, w_full, b_full, aw_hs, w_hs, pair;
    logic [CW-1:0]    aw_cnt, w_cnt, b_cnt;
    logic [ID_W+31:0] aw_head;
    logic [31:0]      w_head, t_diff, t_last, wr_lat;
    logic             unused_wlast;

    assign unused_wlast  = s_axi_wlast;
    assign s_axi_awready = ready_en && !aw_full;
    assign s_axi_wready  = ready_en && !w_full;
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid && s_axi_wready;
    assign pair          = (aw_cnt != '0) && (w_cnt != '0) && !b_full;

    axi_lat_fifo #(.PW(ID_W + 32), .DEPTH(DEPTH)) u_aw_q (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (aw_hs),
        .push_data ({s_axi_awid, now}),
        .pop       (pair),
        .head_data (aw_head),
        .full      (aw_full),
        .count     (aw_cnt)
    );

    axi_lat_fifo #(.PW(32), .DEPTH(DEPTH)) u_w_q (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_hs),
        .push_data (now),
        .pop       (pair),
        .head_data (w_head),
        .full      (w_full),
        .count     (w_cnt)
    );

    // The later of the two arrival stamps starts the write latency; the
    // signed difference keeps the choice correct across timestamp wrap.
    assign t_diff = aw_head[31:0] - w_head;
    assign t_last = t_diff[31] ? w_head : aw_head[31:0];
    assign wr_lat = (cfg_wr_latency < 16'd2) ? 32'd2 : {16'd0, cfg_wr_latency};

    axi_lat_resp_q #(.PW(ID_W), .DEPTH(DEPTH)) u_b_q (
        .clk       (clk),
        .reset_n   (reset_n),
        .now       (now),
        .push      (pair),
        .push_data (aw_head[ID_W+31:32]),
        .push_due  (t_last + wr_lat),
        .full      (b_full),
        .count     (b_cnt),
        .out_valid (s_axi_bvalid),
        .out_ready (s_axi_bready),
        .out_data  (s_axi_bid)
    );

    assign s_axi_bresp    = 2'b00;
    assign rd_outstanding = 8'(rd_cnt);
    assign wr_outstanding = 8'(aw_cnt) + 8'(b_cnt);
endmodule

// File: tb/tb_axi_lat_responder.sv
// Scoreboard bench for axi_lat_responder: stimulus tasks queue expected
// responses, negedge monitors check R and B beats cycle by cycle.

module tb_axi_lat_responder;
    localparam int ID_W   = 12;
    localparam int DATA_W = 512;
    localparam int DEPTH  = 16;
    localparam int K_AR = 0, K_AW = 1, K_W = 2, K_AWW = 3;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [15:0]       cfg_rd_latency = '0, cfg_wr_latency = '0;
    logic              s_axi_arvalid = 1'b0, s_axi_arready;
    logic [ID_W-1:0]   s_axi_arid = '0;
    logic [63:0]       s_axi_araddr = '0;
    logic              s_axi_rvalid, s_axi_rready = 1'b0;
    logic [ID_W-1:0]   s_axi_rid;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_awvalid = 1'b0, s_axi_awready;
    logic [ID_W-1:0]   s_axi_awid = '0;
    logic              s_axi_wvalid = 1'b0, s_axi_wready, s_axi_wlast = 1'b0;
    logic              s_axi_bvalid, s_axi_bready = 1'b0;
    logic [ID_W-1:0]   s_axi_bid;
    logic [1:0]        s_axi_bresp;
    logic [7:0]        rd_outstanding, wr_outstanding;

    always #5 clk = ~clk;

    axi_lat_responder #(.ID_W(ID_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_rd_latency(cfg_rd_latency), .cfg_wr_latency(cfg_wr_latency),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awid(s_axi_awid),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding)
    );

    // Bench copy of the timestamp: cycles since reset release.
    logic [31:0] cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= '0;
        else          cyc <= cyc + 32'd1;
    end

    typedef struct { logic [ID_W-1:0] id; logic [63:0] addr; logic [31:0] due; } rd_exp_t;
    typedef struct { logic [ID_W-1:0] id; logic [31:0] due; } b_exp_t;

    rd_exp_t         rq[$];
    b_exp_t          bq[$];
    logic [ID_W-1:0] awq_id[$];
    logic [31:0]     awq_t[$];
    logic [31:0]     wq_t[$];
    logic [31:0]     first_rv = '1, first_bv = '1;
    int              n_vec = 0, n_fail = 0;

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rep(input logic [63:0] a);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W / 64; i++) r[i*64 +: 64] = a;
        return r;
    endfunction

    function automatic logic ready_ok(input int kind);
        case (kind)
            K_AR:    return s_axi_arready;
            K_AW:    return s_axi_awready;
            K_W:     return s_axi_wready;
            default: return s_axi_awready && s_axi_wready;
        endcase
    endfunction

    function automatic void try_pair();
        b_exp_t      e;
        logic [31:0] ta, tw, d, wl;
        while (awq_t.size() > 0 && wq_t.size() > 0) begin
            ta = awq_t.pop_front();
            tw = wq_t.pop_front();
            d  = ta - tw;
            wl = (cfg_wr_latency < 16'd2) ? 32'd2 : {16'd0, cfg_wr_latency};
            e.id  = awq_id.pop_front();
            e.due = (d[31] ? tw : ta) + wl;
            bq.push_back(e);
        end
    endfunction

    // Drive one channel operation in the current cycle and queue its expectation.
    task automatic applyStimulus(input int kind, input logic [ID_W-1:0] id, input logic [63:0] addr);
        logic    rdy;
        rd_exp_t e;
        int      k;
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_awid    = id;
        s_axi_arvalid = (kind == K_AR);
        s_axi_awvalid = (kind == K_AW) || (kind == K_AWW);
        s_axi_wvalid  = (kind == K_W) || (kind == K_AWW);
        s_axi_wlast   = s_axi_wvalid;
        k   = 0;
        rdy = ready_ok(kind);
        while (!rdy && k < 64) begin
            tick();
            k++;
            rdy = ready_ok(kind);
        end
        checkOutput("ready", rdy, 1);
        if (rdy) begin
            if (kind == K_AR) begin
                e.id   = id;
                e.addr = addr;
                e.due  = cyc + ((cfg_rd_latency == 16'd0) ? 32'd1 : {16'd0, cfg_rd_latency});
                rq.push_back(e);
            end
            if (s_axi_awvalid) begin
                awq_id.push_back(id);
                awq_t.push_back(cyc);
            end
            if (s_axi_wvalid) wq_t.push_back(cyc);
            try_pair();
            tick();
        end
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_wlast   = 1'b0;
    endtask

    task automatic clear_model();
        rq.delete();
        bq.delete();
        awq_id.delete();
        awq_t.delete();
        wq_t.delete();
        first_rv = '1;
        first_bv = '1;
    endtask

    task automatic do_reset();
        tick();
        reset_n = 1'b0;
        clear_model();
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_cyc(input logic [31:0] target);
        for (int k = 0; k < 200 && cyc != target; k++) tick();
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && (rq.size() + bq.size() + awq_t.size() + wq_t.size()) != 0; k++) tick();
        tick();
        checkOutput("drain", rq.size() + bq.size() + awq_t.size() + wq_t.size(), 0);
    endtask

    always @(negedge clk) begin : mon_r
        logic [31:0] d;
        logic        ev;
        ev = 1'b0;
        if (rq.size() > 0) begin
            d  = cyc - rq[0].due;
            ev = !d[31];
        end
        if (reset_n && (s_axi_rvalid || ev)) begin
            if (s_axi_rvalid && first_rv == '1) first_rv = cyc;
            checkOutput("rvalid", s_axi_rvalid, ev);
            if (s_axi_rvalid && ev) begin
                checkOutput("rid", s_axi_rid, rq[0].id);
                checkOutput("rdata", s_axi_rdata, rep(rq[0].addr));
                checkOutput("rlast_rresp", {s_axi_rlast, s_axi_rresp}, 3'b100);
                if (s_axi_rready) void'(rq.pop_front());
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [31:0] d;
        logic        ev;
        ev = 1'b0;
        if (bq.size() > 0) begin
            d  = cyc - bq[0].due;
            ev = !d[31];
        end
        if (reset_n && (s_axi_bvalid || ev)) begin
            if (s_axi_bvalid && first_bv == '1) first_bv = cyc;
            checkOutput("bvalid", s_axi_bvalid, ev);
            if (s_axi_bvalid && ev) begin
                checkOutput("bid", s_axi_bid, bq[0].id);
                checkOutput("bresp", s_axi_bresp, 2'b00);
                if (s_axi_bready) void'(bq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] t0;
        #12;
        checkOutput("reset_readies", {s_axi_arready, s_axi_awready, s_axi_wready}, 3'b000);
        checkOutput("reset_valids", {s_axi_rvalid, s_axi_bvalid}, 2'b00);
        checkOutput("reset_ids", {s_axi_rid, s_axi_bid}, '0);
        checkOutput("reset_rdata", s_axi_rdata, '0);
        checkOutput("reset_outstanding", {rd_outstanding, wr_outstanding}, 16'h0000);
        reset_n = 1'b1;
        tick();
        checkOutput("ready_after_reset", {s_axi_arready, s_axi_awready, s_axi_wready}, 3'b111);

        // Single read, latency 20, AR at cycle 10.
        do_reset();
        cfg_rd_latency = 16'd20;
        s_axi_rready   = 1'b1;
        wait_cyc(32'd10);
        applyStimulus(K_AR, 12'd3, 64'h1000);
        wait_drain();
        checkOutput("rd_first_cycle", first_rv, 32'd30);

        // Fill all 16 read entries, then drain back to back.
        do_reset();
        cfg_rd_latency = 16'd5;
        s_axi_rready   = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) applyStimulus(K_AR, ID_W'(i), 64'h2000 + 64'(i) * 64);
        checkOutput("rd_outstanding_full", rd_outstanding, 8'd16);
        s_axi_arvalid = 1'b1;
        #1;
        checkOutput("arready_full", s_axi_arready, 1'b0);
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        wait_drain();
        checkOutput("rd_outstanding_empty", rd_outstanding, 8'd0);

        // Backpressure: rready low for 10 cycles after rvalid rises.
        do_reset();
        cfg_rd_latency = 16'd3;
        s_axi_rready   = 1'b0;
        tick();
        applyStimulus(K_AR, 12'd9, 64'hABC0);
        for (int k = 0; k < 20 && !s_axi_rvalid; k++) tick();
        checkOutput("rvalid_before_hold", s_axi_rvalid, 1'b1);
        repeat (10) tick();
        checkOutput("rd_outstanding_hold", rd_outstanding, 8'd1);
        s_axi_rready = 1'b1;
        wait_drain();
        checkOutput("rd_outstanding_after_hold", rd_outstanding, 8'd0);

        // Write: W at 5, AW at 12, latency 8 -> B at 20.
        do_reset();
        cfg_wr_latency = 16'd8;
        s_axi_bready   = 1'b1;
        wait_cyc(32'd5);
        applyStimulus(K_W, 12'd0, 64'h0);
        wait_cyc(32'd12);
        applyStimulus(K_AW, 12'd7, 64'h0);
        wait_drain();
        checkOutput("wr_first_cycle_w_first", first_bv, 32'd20);

        // Write: AW at 5, W at 12 -> B at 20.
        do_reset();
        wait_cyc(32'd5);
        applyStimulus(K_AW, 12'd7, 64'h0);
        wait_cyc(32'd12);
        applyStimulus(K_W, 12'd0, 64'h0);
        wait_drain();
        checkOutput("wr_first_cycle_aw_first", first_bv, 32'd20);

        // Zero latency clamps to 1 for reads and 2 for writes.
        do_reset();
        cfg_rd_latency = 16'd0;
        cfg_wr_latency = 16'd0;
        wait_cyc(32'd4);
        applyStimulus(K_AR, 12'd5, 64'h40);
        wait_cyc(32'd6);
        applyStimulus(K_AWW, 12'd2, 64'h0);
        wait_drain();
        checkOutput("rd_first_cycle_lat0", first_rv, 32'd5);
        checkOutput("wr_first_cycle_lat0", first_bv, 32'd8);

        // Reset with 4 reads and 3 writes outstanding.
        do_reset();
        cfg_rd_latency = 16'd2;
        cfg_wr_latency = 16'd2;
        s_axi_rready   = 1'b0;
        s_axi_bready   = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) applyStimulus(K_AR, ID_W'(i + 1), 64'h3000 + 64'(i));
        for (int i = 0; i < 3; i++) applyStimulus(K_AWW, ID_W'(i + 8), 64'h0);
        for (int k = 0; k < 20 && !s_axi_bvalid; k++) tick();
        repeat (5) tick();
        checkOutput("rd_outstanding_pre_reset", rd_outstanding, 8'd4);
        checkOutput("wr_outstanding_pre_reset", wr_outstanding, 8'd3);
        checkOutput("valids_pre_reset", {s_axi_rvalid, s_axi_bvalid}, 2'b11);
        reset_n = 1'b0;
        clear_model();
        #1;
        checkOutput("valids_in_reset", {s_axi_rvalid, s_axi_bvalid}, 2'b00);
        checkOutput("outstanding_in_reset", {rd_outstanding, wr_outstanding}, 16'h0000);
        tick();
        reset_n      = 1'b1;
        s_axi_rready = 1'b1;
        s_axi_bready = 1'b1;
        repeat (30) tick();
        checkOutput("valids_after_reset", {s_axi_rvalid, s_axi_bvalid}, 2'b00);
        t0 = cyc;
        applyStimulus(K_AR, 12'd1, 64'h80);
        wait_drain();
        checkOutput("rd_first_cycle_post_reset", first_rv, t0 + 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
